load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store bus sequencer with byte-lane steering
// Optional bus-wait timeout enabled by defining LSU_BUS_TIMEOUT_EN.
module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] rdata_aligned,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [1:0]        off_q, off_d;

    logic              misaligned;
    logic [3:0]        be_req;
    logic [XLEN-1:0]   wdata_rep;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic timeout_param_unused;
    assign timeout_param_unused = (TIMEOUT_CYCLES > 0);
`endif

    logic funct3_sign_unused;
    assign funct3_sign_unused = funct3[2];

    // Lane selection depends only on size (funct3[1:0]); signedness is handled downstream.
    always_comb begin
        misaligned = 1'b0;
        be_req     = 4'b1111;
        wdata_rep  = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_req    = 4'b0001 << addr[1:0];
                wdata_rep = {(XLEN/8){wdata[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                be_req     = 4'b0011 << addr[1:0];
                wdata_rep  = {(XLEN/16){wdata[15:0]}};
            end
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        off_d       = off_q;
`ifdef LSU_BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    rdata_d = '0;
                    if (misaligned) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        err_d       = 1'b0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store;
                        bus_addr_d  = {addr[XLEN-1:2], 2'b00};
                        bus_wdata_d = wdata_rep;
                        bus_be_d    = be_req;
                        off_d       = addr[1:0];
`ifdef LSU_BUS_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                if (bus_ack) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    rdata_d   = bus_we_q ? '0 : (bus_rdata >> {off_q, 3'b000});
                end
`ifdef LSU_BUS_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= 4'b0000;
            off_q       <= 2'b00;
`ifdef LSU_BUS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            off_q       <= off_d;
`ifdef LSU_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rdata_aligned = rdata_q;
    assign bus_req       = bus_req_q;
    assign bus_we        = bus_we_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_be        = bus_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector table, random model comparison and corner sequences for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata_aligned;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int total = 0;
    int bad = 0;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata_aligned(rdata_aligned),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] brd;
        int          waits;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rd;
        logic        e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: access size in bytes, alignment by modulo, lanes as a contiguous byte mask.
    task automatic model(input vec_t v, output vec_t r);
        int size, off;
        r = v;
        size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(v.a % 4);
        r.e = (v.a % size) != 0;
        r.be = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << off);
        r.bwd = (size == 1) ? (v.wd & 32'hFF) * 32'h01010101 :
                (size == 2) ? (v.wd & 32'hFFFF) * 32'h00010001 : v.wd;
        r.rd = (r.e || v.st) ? 32'h0 : v.brd >> (8 * off);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        start = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.a; wdata = v.wd;
        step();
        start = 1'b0; wdata = 32'h5A5A5A5A; addr = 32'hFFFF_FFFF;
        if (v.e) begin
            chk({tag, " mis done"}, done, 1);
            chk({tag, " mis err"}, err, 1);
            chk({tag, " mis bus_req"}, bus_req, 0);
            chk({tag, " mis rdata"}, rdata_aligned, 0);
            step();
            chk({tag, " mis idle"}, {busy, done}, 0);
            return;
        end
        chk({tag, " req"}, {busy, bus_req, done}, 3'b110);
        chk({tag, " we"}, bus_we, v.st);
        chk({tag, " addr"}, bus_addr, v.a & 32'hFFFF_FFFC);
        chk({tag, " be"}, bus_be, v.be);
        if (v.st) chk({tag, " wdata"}, bus_wdata, v.bwd);
        for (int w = 0; w < v.waits; w++) begin
            step();
            chk({tag, " wait stable"}, {bus_req, done, bus_be, bus_addr}, {2'b10, v.be, v.a & 32'hFFFF_FFFC});
        end
        bus_ack = 1'b1; bus_rdata = v.brd;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0BAD0BAD;
        chk({tag, " done"}, {done, err, bus_req}, 3'b100);
        chk({tag, " rdata"}, rdata_aligned, v.rd);
        step();
        chk({tag, " after"}, {done, busy}, 0);
        chk({tag, " hold"}, {err, rdata_aligned}, {1'b0, v.rd});
    endtask

    vec_t tbl[12];
    vec_t rv, rexp;
    int ndone, done_cyc;

    initial begin
        // st f3 addr wdata bus_rdata waits be bus_wdata rdata err
        tbl[0]  = '{0, 3'b000, 32'h1003, 32'h0,        32'h80AABBCC, 0, 4'b1000, 32'h0,        32'h00000080, 0};
        tbl[1]  = '{1, 3'b001, 32'h2002, 32'h1234ABCD, 32'hFFFFFFFF, 3, 4'b1100, 32'hABCDABCD, 32'h0,        0};
        tbl[2]  = '{0, 3'b010, 32'h3001, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1};
        tbl[3]  = '{0, 3'b101, 32'h3001, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1};
        tbl[4]  = '{0, 3'b010, 32'h0400, 32'h0,        32'hDEADBEEF, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 0};
        tbl[5]  = '{0, 3'b001, 32'h0402, 32'h0,        32'hCAFEF00D, 0, 4'b1100, 32'h0,        32'h0000CAFE, 0};
        tbl[6]  = '{1, 3'b000, 32'h0501, 32'h000000A5, 32'h0,        2, 4'b0010, 32'hA5A5A5A5, 32'h0,        0};
        tbl[7]  = '{0, 3'b100, 32'h0602, 32'h0,        32'h11223344, 0, 4'b0100, 32'h0,        32'h00001122, 0};
        tbl[8]  = '{1, 3'b010, 32'h0704, 32'h89ABCDEF, 32'h0,        1, 4'b1111, 32'h89ABCDEF, 32'h0,        0};
        tbl[9]  = '{1, 3'b001, 32'h0703, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1};
        tbl[10] = '{0, 3'b011, 32'h0802, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1};
        tbl[11] = '{0, 3'b011, 32'h0800, 32'h0,        32'h76543210, 0, 4'b1111, 32'h0,        32'h76543210, 0};

        #3;
        chk("reset ctrl", {busy, done, err, bus_req, bus_we}, 0);
        chk("reset be", bus_be, 0);
        chk("reset bus", bus_addr | bus_wdata | rdata_aligned, 0);
        step(); step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rv.st = 1'($urandom_range(0, 1));
            rv.f3 = 3'($urandom_range(0, 7));
            rv.a = $urandom;
            rv.wd = $urandom;
            rv.brd = $urandom;
            rv.waits = $urandom_range(0, 3);
            model(rv, rexp);
            run_txn(rexp, $sformatf("rnd%0d", i));
        end

        // start pulses during ACCESS and RESP are ignored
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100;
        step();
        addr = 32'h3001;
        step();
        start = 1'b0;
        chk("ign addr", bus_addr, 32'h100);
        chk("ign req", bus_req, 1);
        bus_ack = 1'b1; bus_rdata = 32'h13579BDF;
        step();
        bus_ack = 1'b0;
        ndone = 0;
        if (done) ndone++;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (done) ndone++;
            step();
        end
        chk("ign one done", ndone, 1);
        chk("ign idle", {busy, bus_req, err}, 0);
        chk("ign rdata", rdata_aligned, 32'h13579BDF);

        // reset mid-ACCESS abandons the access
        start = 1'b1; funct3 = 3'b010; addr = 32'h200;
        step();
        start = 1'b0;
        chk("rst pre req", bus_req, 1);
        reset = 1'b1;
        #1;
        chk("rst async", {bus_req, busy, done}, 0);
        step();
        reset = 1'b0;
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            if (done || busy) ndone++;
            step();
        end
        chk("rst no done", ndone, 0);

        // no acknowledge at all
        start = 1'b1; funct3 = 3'b010; addr = 32'h900;
        step();
        start = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= 1000; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            step();
        end
`ifdef LSU_BUS_TIMEOUT_EN
        chk("tmo cycle", done_cyc, 5);
        chk("tmo err", {err, bus_req}, 2'b10);
        chk("tmo rdata", rdata_aligned, 0);
        step();
        chk("tmo idle", busy, 0);
`else
        chk("noack no done", done_cyc, -1);
        chk("noack busy", {busy, bus_req}, 2'b11);
        bus_ack = 1'b1; bus_rdata = 32'h2468ACE0;
        step();
        bus_ack = 1'b0;
        chk("noack late done", {done, err}, 2'b10);
        chk("noack rdata", rdata_aligned, 32'h2468ACE0);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
